// File: rtl/operand_buffer.sv
// Double-banked operand store feeding the 2x2 systolic array: host bytes land in a
// write bank, the whole pair is committed on the address-7 byte, and lanes read the active bank.
module operand_lane #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic [1:0]    sel_i,
    input  logic [DW-1:0] c0_i,
    input  logic [DW-1:0] c1_i,
    output logic [DW-1:0] q_o
);
    logic [DW-1:0] q_d, q_q;

    always_comb begin
        q_d = '0;
        if (en_i) begin
            case (sel_i)
                2'd0:    q_d = c0_i;
                2'd1:    q_d = c1_i;
                default: q_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_q <= '0;
        else     q_q <= q_d;
    end

    assign q_o = q_q;
endmodule

module operand_buffer #(
    parameter int DW    = 8,
    parameter int DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_en,
    input  logic [2:0]           mem_addr,
    input  logic [DW-1:0]        host_indata,
    input  logic                 transpose,
    input  logic [1:0]           a0_sel,
    input  logic [1:0]           a1_sel,
    input  logic [1:0]           b0_sel,
    input  logic [1:0]           b1_sel,
    output logic signed [DW-1:0] a0,
    output logic signed [DW-1:0] a1,
    output logic signed [DW-1:0] b0,
    output logic signed [DW-1:0] b1,
    output logic                 bank_valid,
    output logic                 commit,
    output logic                 seq_err
);
    localparam int NUM_LANES = 4;

    logic [DEPTH-1:0][DW-1:0] wbank_d, wbank_q, active_d, active_q;
    logic [2:0] ptr_d, ptr_q;
    logic       seq_err_d, seq_err_q;
    logic       bank_valid_d, bank_valid_q;
    logic       commit_d, commit_q;

    always_comb begin
        wbank_d      = wbank_q;
        active_d     = active_q;
        ptr_d        = ptr_q;
        seq_err_d    = seq_err_q;
        commit_d     = load_en && (mem_addr == 3'd7);
        bank_valid_d = bank_valid_q | commit_d;
        if (load_en) begin
            wbank_d[mem_addr] = host_indata;
            ptr_d             = mem_addr + 3'd1;
            if (mem_addr != ptr_q) seq_err_d = 1'b1;
        end
        // wbank_d already holds the addr-7 byte, giving the same-cycle bypass
        if (commit_d) active_d = wbank_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbank_q      <= '0;
            active_q     <= '0;
            ptr_q        <= '0;
            seq_err_q    <= 1'b0;
            bank_valid_q <= 1'b0;
            commit_q     <= 1'b0;
        end else begin
            wbank_q      <= wbank_d;
            active_q     <= active_d;
            ptr_q        <= ptr_d;
            seq_err_q    <= seq_err_d;
            bank_valid_q <= bank_valid_d;
            commit_q     <= commit_d;
        end
    end

    // Lane order a0, a1, b0, b1; transpose only swaps X1/X2 between the b lanes
    logic [NUM_LANES-1:0][1:0]    sel;
    logic [NUM_LANES-1:0][DW-1:0] cand0, cand1, opnd;

    always_comb begin
        sel      = {b1_sel, b0_sel, a1_sel, a0_sel};
        cand0[0] = active_q[0];
        cand1[0] = active_q[1];
        cand0[1] = active_q[2];
        cand1[1] = active_q[3];
        cand0[2] = active_q[4];
        cand1[2] = transpose ? active_q[6] : active_q[5];
        cand0[3] = transpose ? active_q[5] : active_q[6];
        cand1[3] = active_q[7];
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        operand_lane #(.DW(DW)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .en_i  (bank_valid_q),
            .sel_i (sel[g]),
            .c0_i  (cand0[g]),
            .c1_i  (cand1[g]),
            .q_o   (opnd[g])
        );
    end

    assign a0         = opnd[0];
    assign a1         = opnd[1];
    assign b0         = opnd[2];
    assign b1         = opnd[3];
    assign bank_valid = bank_valid_q;
    assign commit     = commit_q;
    assign seq_err    = seq_err_q;
endmodule
